// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - constants and types shared by the fetch unit and memory controller
package cpu_pkg;

   localparam int CPU_ADDR_W = 16;
   localparam int CPU_DATA_W = 32;

   localparam logic [3:0] OP_LDR  = 4'hD;
   localparam logic [3:0] OP_STR  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_MEM    = 2'd2,
      ST_HALTED = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program counter and instruction fetch from the shared RAM
// Yields the RAM address path to the memory controller and handles branch redirect and HALT.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int                     ADDR_W      = CPU_ADDR_W,
   parameter int                     DATA_W      = CPU_DATA_W,
   parameter logic [ADDR_W-1:0]      RESET_PC    = '0,
   parameter int                     RAM_LATENCY = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              mem_busy,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              fetch_req,
   output logic [ADDR_W-1:0] pc_addr,
   output logic [DATA_W-1:0] instr,
   output logic [3:0]        opcode,
   output logic              instr_valid,
   output logic              halted
);

   localparam logic [1:0] CNT_LAST = 2'(RAM_LATENCY - 1);

   fetch_state_t      r_state;
   logic [1:0]        r_cnt;
   logic [ADDR_W-1:0] r_pc;
   logic [DATA_W-1:0] r_instr;

   fetch_state_t      w_state_next;
   logic [1:0]        w_cnt_next;
   logic [ADDR_W-1:0] w_pc_next;
   logic              w_capture;
   logic [3:0]        w_opcode;

   assign w_opcode = r_instr[DATA_W-1 -: 4];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_FETCH;
         r_cnt   <= '0;
         r_pc    <= RESET_PC;
         r_instr <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_pc    <= w_pc_next;
         if (w_capture) begin
            r_instr <= ram_rdata;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_pc_next    = r_pc;
      w_capture    = 1'b0;

      case (r_state)
         ST_FETCH: begin
            // Any stall restarts the latency count: the RAM saw a foreign address.
            if (mem_busy) begin
               w_cnt_next = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_capture    = 1'b1;
               w_cnt_next   = '0;
               w_state_next = ST_ISSUE;
            end else begin
               w_cnt_next = r_cnt + 2'd1;
            end
         end
         ST_ISSUE: begin
            w_pc_next = r_pc + 1'b1;
            if (w_opcode == OP_LDR || w_opcode == OP_STR) begin
               w_state_next = ST_MEM;
            end else if (w_opcode == OP_HALT) begin
               w_state_next = ST_HALTED;
            end else begin
               w_state_next = ST_FETCH;
            end
         end
         ST_MEM: begin
            w_state_next = ST_FETCH;
         end
         default: begin
            w_state_next = ST_HALTED;
         end
      endcase

      // Redirect overrides sequencing and drops any word in flight.
      if (branch_taken && r_state != ST_HALTED) begin
         w_pc_next    = branch_target;
         w_cnt_next   = '0;
         w_state_next = ST_FETCH;
         w_capture    = 1'b0;
      end
   end

   assign fetch_req   = (r_state == ST_FETCH) && !mem_busy;
   assign pc_addr     = r_pc;
   assign instr       = r_instr;
   assign opcode      = w_opcode;
   assign instr_valid = (r_state == ST_ISSUE);
   assign halted      = (r_state == ST_HALTED);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
// Two instances: RAM latency 1 and RAM latency 3, sharing one RAM image.
module tb_instr_fetch_unit;

   logic        clock = 1'b0;
   always #5 clock = ~clock;

   logic [31:0] mem [0:65535];

   logic        reset, mem_busy, branch_taken;
   logic [15:0] branch_target;
   logic [31:0] ram_rdata;
   logic        fetch_req, instr_valid, halted;
   logic [15:0] pc_addr;
   logic [31:0] instr;
   logic [3:0]  opcode;

   logic        reset3, mem_busy3, branch_taken3;
   logic [15:0] branch_target3;
   logic [31:0] ram_rdata3;
   logic        fetch_req3, instr_valid3, halted3;
   logic [15:0] pc_addr3;
   logic [31:0] instr3;
   logic [3:0]  opcode3;

   assign ram_rdata  = mem[pc_addr];
   assign ram_rdata3 = mem[pc_addr3];

   instr_fetch_unit #(.RESET_PC(16'h0000), .RAM_LATENCY(1)) u_dut (
      .clock(clock), .reset(reset), .mem_busy(mem_busy),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .ram_rdata(ram_rdata), .fetch_req(fetch_req), .pc_addr(pc_addr),
      .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .halted(halted)
   );

   instr_fetch_unit #(.RESET_PC(16'h0000), .RAM_LATENCY(3)) u_dut3 (
      .clock(clock), .reset(reset3), .mem_busy(mem_busy3),
      .branch_taken(branch_taken3), .branch_target(branch_target3),
      .ram_rdata(ram_rdata3), .fetch_req(fetch_req3), .pc_addr(pc_addr3),
      .instr(instr3), .opcode(opcode3), .instr_valid(instr_valid3), .halted(halted3)
   );

   logic        sel;
   logic        o_req, o_valid, o_halt;
   logic [15:0] o_pc;
   logic [31:0] o_instr;
   logic [3:0]  o_op;
   assign o_req   = sel ? fetch_req3   : fetch_req;
   assign o_valid = sel ? instr_valid3 : instr_valid;
   assign o_halt  = sel ? halted3      : halted;
   assign o_pc    = sel ? pc_addr3     : pc_addr;
   assign o_instr = sel ? instr3       : instr;
   assign o_op    = sel ? opcode3      : opcode;

   typedef struct {
      logic [31:0] instr;
      logic [15:0] pc;
      int          cycles;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   // Pushes the expected issue, then waits (bounded) for the pulse and scores it.
   task automatic expect_issue(input string tag, input logic [31:0] ei, input logic [15:0] ep,
                               input int ec);
      exp_t e;
      int   n;
      sb.push_back('{ei, ep, ec});
      n = 0;
      do begin
         tick();
         n++;
      end while (!o_valid && n < 20);
      e = sb.pop_front();
      check({tag, "_valid"}, o_valid, 1'b1);
      check({tag, "_instr"}, o_instr, e.instr);
      check({tag, "_opcode"}, o_op, e.instr[31:28]);
      check({tag, "_pc"}, o_pc, e.pc);
      check({tag, "_cycles"}, n, e.cycles);
   endtask

   initial begin
      mem[16'h0000] = 32'h1000_0001;
      mem[16'h0001] = 32'h2000_0002;
      mem[16'h0002] = 32'hD000_0010;
      mem[16'h0003] = 32'h3000_0003;
      mem[16'h0004] = 32'h4000_0004;
      mem[16'h0005] = 32'h5000_0005;
      mem[16'h0040] = 32'h6000_0040;
      mem[16'h0041] = 32'h6100_0041;
      mem[16'h0080] = 32'hF000_0000;
      mem[16'hFFFF] = 32'h7000_FFFF;

      sel = 1'b0;
      reset = 1'b1; mem_busy = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
      reset3 = 1'b1; mem_busy3 = 1'b0; branch_taken3 = 1'b0; branch_target3 = 16'h0000;

      tick();
      tick();
      check("rst_req", o_req, 1'b1);
      check("rst_pc", o_pc, 16'h0000);
      check("rst_instr", o_instr, 32'h0);
      check("rst_opcode", o_op, 4'h0);
      check("rst_valid", o_valid, 1'b0);
      check("rst_halted", o_halt, 1'b0);
      reset = 1'b0;

      expect_issue("alu0", 32'h1000_0001, 16'h0000, 1);
      expect_issue("alu1", 32'h2000_0002, 16'h0001, 2);
      expect_issue("ldr", 32'hD000_0010, 16'h0002, 2);

      tick();
      mem_busy = 1'b1;
      #1;
      check("mem_req", o_req, 1'b0);
      check("mem_valid", o_valid, 1'b0);
      check("mem_pc", o_pc, 16'h0003);
      tick();
      check("stall1_req", o_req, 1'b0);
      check("stall1_valid", o_valid, 1'b0);
      tick();
      check("stall2_req", o_req, 1'b0);
      check("stall2_valid", o_valid, 1'b0);
      mem_busy = 1'b0;
      #1;
      check("unstall_req", o_req, 1'b1);
      expect_issue("after_ldr", 32'h3000_0003, 16'h0003, 1);
      expect_issue("alu4", 32'h4000_0004, 16'h0004, 2);

      tick();
      branch_taken = 1'b1; branch_target = 16'h0040;
      #1;
      check("br_pre_pc", o_pc, 16'h0005);
      check("br_pre_valid", o_valid, 1'b0);
      tick();
      branch_taken = 1'b0;
      #1;
      check("br_pc", o_pc, 16'h0040);
      check("br_valid", o_valid, 1'b0);
      expect_issue("br_target", 32'h6000_0040, 16'h0040, 1);
      tick();
      check("br_inc_pc", o_pc, 16'h0041);

      branch_taken = 1'b1; branch_target = 16'hFFFF;
      tick();
      branch_taken = 1'b0;
      expect_issue("top", 32'h7000_FFFF, 16'hFFFF, 1);
      tick();
      check("wrap_pc", o_pc, 16'h0000);
      check("wrap_req", o_req, 1'b1);

      expect_issue("wrap_alu0", 32'h1000_0001, 16'h0000, 1);
      expect_issue("wrap_alu1", 32'h2000_0002, 16'h0001, 2);
      expect_issue("wrap_ldr", 32'hD000_0010, 16'h0002, 2);
      branch_taken = 1'b1; branch_target = 16'h0080;
      tick();
      branch_taken = 1'b0;
      #1;
      check("br_issue_pc", o_pc, 16'h0080);
      check("br_issue_req", o_req, 1'b1);
      expect_issue("halt_issue", 32'hF000_0000, 16'h0080, 1);
      tick();
      check("halt_flag", o_halt, 1'b1);
      check("halt_req", o_req, 1'b0);
      check("halt_pc", o_pc, 16'h0081);
      branch_taken = 1'b1; branch_target = 16'h0010;
      tick();
      tick();
      branch_taken = 1'b0;
      #1;
      check("halt_br_flag", o_halt, 1'b1);
      check("halt_br_pc", o_pc, 16'h0081);
      check("halt_br_valid", o_valid, 1'b0);
      check("halt_br_req", o_req, 1'b0);

      reset = 1'b1;
      #1;
      check("hrst_pc", o_pc, 16'h0000);
      check("hrst_halted", o_halt, 1'b0);
      check("hrst_req", o_req, 1'b1);
      check("hrst_instr", o_instr, 32'h0);
      tick();
      reset = 1'b0;
      expect_issue("hrst_alu0", 32'h1000_0001, 16'h0000, 1);
      reset = 1'b1;

      sel = 1'b1;
      reset3 = 1'b0;
      expect_issue("l3_first", 32'h1000_0001, 16'h0000, 3);
      tick();
      tick();
      check("l3_mid_pc", o_pc, 16'h0001);
      reset3 = 1'b1;
      #1;
      check("l3_rst_pc", o_pc, 16'h0000);
      check("l3_rst_instr", o_instr, 32'h0);
      check("l3_rst_valid", o_valid, 1'b0);
      check("l3_rst_req", o_req, 1'b1);
      tick();
      reset3 = 1'b0;
      expect_issue("l3_after_rst", 32'h1000_0001, 16'h0000, 3);
      tick();
      tick();
      mem_busy3 = 1'b1;
      tick();
      mem_busy3 = 1'b0;
      expect_issue("l3_restart", 32'h2000_0002, 16'h0001, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
